// File: rtl/usb2ether_pkt_fifo_pkg.sv
// Shared constants and helpers for the USB-to-Ethernet packet FIFO.
// Each side (write/read) resolves its control inputs to one action per cycle.
package usb2ether_pkg;

    localparam int unsigned USB2ETHER_FIFO_DW    = 8;
    localparam int unsigned USB2ETHER_FIFO_AW    = 9;
    localparam int unsigned USB2ETHER_FIFO_AFULL = 448;

    typedef enum logic [1:0] {
        OP_PLAIN = 2'd0,
        OP_START = 2'd1,
        OP_ERROR = 2'd2
    } side_op_e;

    // Error outranks start; start outranks a plain access.
    function automatic side_op_e side_op(input logic err, input logic start);
        if (err)   return OP_ERROR;
        if (start) return OP_START;
        return OP_PLAIN;
    endfunction

endpackage

// File: rtl/usb2ether_pkt_fifo_if.sv
// Writer/reader control and status bundle of the packet FIFO.
// master = USB engine + MAC side driving controls, slave = the FIFO.
interface usb2ether_pkt_fifo_if
    import usb2ether_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = USB2ETHER_FIFO_DW,
    parameter int unsigned ADDR_WIDTH = USB2ETHER_FIFO_AW
);
    logic                  clear;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_start;
    logic                  write_commit;
    logic                  write_error;
    logic                  read_enable;
    logic                  read_start;
    logic                  read_done;
    logic                  read_error;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   fill_level;

    modport master (
        output clear, write_enable, write_data, write_start, write_commit, write_error,
        output read_enable, read_start, read_done, read_error,
        input  read_data, fifo_empty, fifo_full, almost_full, fill_level
    );

    modport slave (
        input  clear, write_enable, write_data, write_start, write_commit, write_error,
        input  read_enable, read_start, read_done, read_error,
        output read_data, fifo_empty, fifo_full, almost_full, fill_level
    );
endinterface

// File: rtl/usb2ether_pkt_fifo_ram.sv
// Simple dual-port memory: synchronous write, registered read.
// Only the output register is reset; the array itself is never cleared.
module usb2ether_pkt_fifo_ram
    import usb2ether_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = USB2ETHER_FIFO_DW,
    parameter int unsigned ADDR_WIDTH = USB2ETHER_FIFO_AW
)(
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/usb2ether_pkt_fifo.sv
// Packet FIFO with commit/discard on the write side and release/replay on the read side.
// Pointers carry one extra wrap bit so full and empty stay distinguishable.
module usb2ether_pkt_fifo
    import usb2ether_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = USB2ETHER_FIFO_DW,
    parameter int unsigned ADDR_WIDTH   = USB2ETHER_FIFO_AW,
    parameter int unsigned AFULL_THRESH = USB2ETHER_FIFO_AFULL
)(
    input logic                 clk,
    input logic                 rst,
    usb2ether_pkt_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_wr_cmt;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_rd_rel;

    logic [PW-1:0] w_wr_ptr_nxt;
    logic [PW-1:0] w_wr_addr;
    logic [PW-1:0] w_rd_ptr_nxt;
    logic [PW-1:0] w_rd_addr;
    logic [PW-1:0] w_fill;
    logic          w_flush;
    logic          w_empty;
    logic          w_full;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_mem_we;
    logic          w_mem_re;
    side_op_e      w_wr_op;
    side_op_e      w_rd_op;

    assign w_flush = rst | bus.clear;

    // Occupancy counts up to the release point, so read-but-unreleased words still hold space.
    assign w_fill  = r_wr_ptr - r_rd_rel;
    assign w_empty = (r_rd_ptr == r_wr_cmt);
    assign w_full  = (w_fill == PW'(DEPTH));

    assign w_wr_acc = bus.write_enable & ~w_full;
    assign w_rd_acc = bus.read_enable & ~w_empty;
    assign w_wr_op  = side_op(bus.write_error, bus.write_start);
    assign w_rd_op  = side_op(bus.read_error, bus.read_start);

    always_comb begin
        w_mem_we     = 1'b0;
        w_wr_addr    = r_wr_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        case (w_wr_op)
            OP_ERROR: begin
                w_wr_ptr_nxt = r_wr_cmt;
            end
            OP_START: begin
                w_wr_addr    = r_wr_cmt;
                w_mem_we     = w_wr_acc;
                w_wr_ptr_nxt = r_wr_cmt + PW'(w_wr_acc);
            end
            default: begin
                w_mem_we     = w_wr_acc;
                w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_acc);
            end
        endcase
    end

    always_comb begin
        w_mem_re     = 1'b0;
        w_rd_addr    = r_rd_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        case (w_rd_op)
            OP_ERROR: begin
                w_rd_ptr_nxt = r_rd_rel;
            end
            OP_START: begin
                w_rd_addr    = r_rd_rel;
                w_mem_re     = w_rd_acc;
                w_rd_ptr_nxt = r_rd_rel + PW'(w_rd_acc);
            end
            default: begin
                w_mem_re     = w_rd_acc;
                w_rd_ptr_nxt = r_rd_ptr + PW'(w_rd_acc);
            end
        endcase
    end

    // Commit/release capture the post-access pointer so a same-cycle word is included.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wr_ptr <= '0;
            r_wr_cmt <= '0;
            r_rd_ptr <= '0;
            r_rd_rel <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            if (bus.write_commit && (w_wr_op != OP_ERROR)) begin
                r_wr_cmt <= w_wr_ptr_nxt;
            end
            if (bus.read_done && (w_rd_op != OP_ERROR)) begin
                r_rd_rel <= w_rd_ptr_nxt;
            end
        end
    end

    usb2ether_pkt_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_rst   (w_flush),
        .i_we    (w_mem_we & ~w_flush),
        .i_waddr (w_wr_addr[ADDR_WIDTH-1:0]),
        .i_wdata (bus.write_data),
        .i_re    (w_mem_re & ~w_flush),
        .i_raddr (w_rd_addr[ADDR_WIDTH-1:0]),
        .o_rdata (bus.read_data)
    );

    assign bus.fifo_empty  = w_empty;
    assign bus.fifo_full   = w_full;
    assign bus.almost_full = (w_fill >= PW'(AFULL_THRESH));
    assign bus.fill_level  = w_fill;
endmodule

// File: tb/tb_usb2ether_pkt_fifo.sv
// Directed bench for usb2ether_pkt_fifo at default size (512 x 8, almost-full at 448).
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_usb2ether_pkt_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    usb2ether_pkt_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(9)) bus ();

    usb2ether_pkt_fifo #(
        .DATA_WIDTH   (8),
        .ADDR_WIDTH   (9),
        .AFULL_THRESH (448)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clear        = 1'b0;
        bus.write_enable = 1'b0;
        bus.write_data   = 8'h00;
        bus.write_start  = 1'b0;
        bus.write_commit = 1'b0;
        bus.write_error  = 1'b0;
        bus.read_enable  = 1'b0;
        bus.read_start   = 1'b0;
        bus.read_done    = 1'b0;
        bus.read_error   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input bit cmt);
        bus.write_enable = 1'b1;
        bus.write_data   = d;
        bus.write_commit = cmt;
        tick();
        idle();
    endtask

    task automatic pop(input bit done);
        bus.read_enable = 1'b1;
        bus.read_done   = done;
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_empty", 32'(bus.fifo_empty), 32'd1);
        chk("rst_full",  32'(bus.fifo_full),  32'd0);
        chk("rst_afull", 32'(bus.almost_full), 32'd0);
        chk("rst_fill",  32'(bus.fill_level), 32'd0);
        chk("rst_rdata", 32'(bus.read_data),  32'd0);

        // Single word: invisible until commit, space held until release
        push(8'hFF, 1'b0);
        chk("one_empty_precommit", 32'(bus.fifo_empty), 32'd1);
        chk("one_fill_precommit",  32'(bus.fill_level), 32'd1);
        bus.write_commit = 1'b1;
        tick();
        idle();
        chk("one_empty_postcommit", 32'(bus.fifo_empty), 32'd0);
        pop(1'b0);
        chk("one_rdata", 32'(bus.read_data),  32'hFF);
        chk("one_empty", 32'(bus.fifo_empty), 32'd1);
        chk("one_fill_unrel", 32'(bus.fill_level), 32'd1);
        bus.read_done = 1'b1;
        tick();
        idle();
        chk("one_fill_rel", 32'(bus.fill_level), 32'd0);

        // Fill to capacity
        for (int i = 0; i < 512; i++) begin
            push(8'(i), i == 511);
            if (i == 446) chk("fill_afull_447", 32'(bus.almost_full), 32'd0);
            if (i == 447) begin
                chk("fill_afull_448", 32'(bus.almost_full), 32'd1);
                chk("fill_lvl_448",   32'(bus.fill_level),  32'd448);
            end
        end
        chk("fill_full",  32'(bus.fifo_full),  32'd1);
        chk("fill_lvl",   32'(bus.fill_level), 32'd512);
        chk("fill_empty", 32'(bus.fifo_empty), 32'd0);
        push(8'hAA, 1'b1);
        chk("fill_513_lvl",  32'(bus.fill_level), 32'd512);
        chk("fill_513_full", 32'(bus.fifo_full),  32'd1);
        for (int i = 0; i < 512; i++) begin
            pop(1'b0);
            chk("fill_rd", 32'(bus.read_data), 32'(i & 255));
        end
        chk("fill_drained_empty", 32'(bus.fifo_empty), 32'd1);
        chk("fill_unrel_full",    32'(bus.fifo_full),  32'd1);
        bus.read_done = 1'b1;
        tick();
        idle();
        chk("fill_rel_lvl",  32'(bus.fill_level), 32'd0);
        chk("fill_rel_full", 32'(bus.fifo_full),  32'd0);

        // Discard an uncommitted tail
        for (int i = 0; i < 256; i++) push(8'(i), i == 255);
        for (int i = 0; i < 255; i++) push(8'h55, 1'b0);
        chk("disc_lvl_pre",   32'(bus.fill_level),  32'd511);
        chk("disc_afull_pre", 32'(bus.almost_full), 32'd1);
        bus.write_error = 1'b1;
        tick();
        idle();
        chk("disc_lvl_post", 32'(bus.fill_level), 32'd256);
        for (int i = 0; i < 256; i++) begin
            pop(1'b0);
            chk("disc_rd", 32'(bus.read_data), 32'(i));
        end
        chk("disc_empty", 32'(bus.fifo_empty), 32'd1);
        pop(1'b0);
        chk("disc_rd_rejected_hold", 32'(bus.read_data), 32'hFF);
        bus.read_done = 1'b1;
        tick();
        idle();
        chk("disc_rel_lvl", 32'(bus.fill_level), 32'd0);

        // Replay from the release point on a full FIFO
        for (int i = 0; i < 512; i++) push(8'(i * 7), i == 511);
        for (int i = 0; i < 100; i++) begin
            pop(1'b0);
            chk("rep_rd", 32'(bus.read_data), 32'((i * 7) & 255));
        end
        chk("rep_full_unrel", 32'(bus.fifo_full),  32'd1);
        chk("rep_lvl_unrel",  32'(bus.fill_level), 32'd512);
        bus.read_error  = 1'b1;
        bus.read_enable = 1'b1;
        bus.read_done   = 1'b1;
        tick();
        idle();
        chk("rep_err_hold", 32'(bus.read_data),  32'd181);
        chk("rep_err_lvl",  32'(bus.fill_level), 32'd512);
        bus.read_start  = 1'b1;
        bus.read_enable = 1'b1;
        tick();
        idle();
        chk("rep_start_rd", 32'(bus.read_data), 32'd0);
        for (int i = 1; i < 100; i++) begin
            pop(1'b0);
            chk("rep_rd2", 32'(bus.read_data), 32'((i * 7) & 255));
        end
        pop(1'b1);
        chk("rep_done_rd",    32'(bus.read_data),   32'd188);
        chk("rep_done_lvl",   32'(bus.fill_level),  32'd411);
        chk("rep_done_full",  32'(bus.fifo_full),   32'd0);
        chk("rep_done_afull", 32'(bus.almost_full), 32'd0);

        // Clear wins over a same-cycle write
        bus.clear        = 1'b1;
        bus.write_enable = 1'b1;
        bus.write_data   = 8'h99;
        bus.write_commit = 1'b1;
        tick();
        idle();
        chk("clr_empty", 32'(bus.fifo_empty), 32'd1);
        chk("clr_lvl",   32'(bus.fill_level), 32'd0);
        chk("clr_full",  32'(bus.fifo_full),  32'd0);
        chk("clr_rdata", 32'(bus.read_data),  32'd0);

        // Same-cycle combinations
        push(8'h3C, 1'b1);
        chk("sim_wc_lvl",   32'(bus.fill_level), 32'd1);
        chk("sim_wc_empty", 32'(bus.fifo_empty), 32'd0);
        bus.write_enable = 1'b1;
        bus.write_data   = 8'h77;
        bus.write_error  = 1'b1;
        bus.write_commit = 1'b1;
        tick();
        idle();
        chk("sim_we_lvl", 32'(bus.fill_level), 32'd1);
        pop(1'b1);
        chk("sim_rd_data",  32'(bus.read_data),  32'h3C);
        chk("sim_rd_lvl",   32'(bus.fill_level), 32'd0);
        chk("sim_rd_empty", 32'(bus.fifo_empty), 32'd1);
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        chk("ws_lvl_pre", 32'(bus.fill_level), 32'd2);
        bus.write_start  = 1'b1;
        bus.write_enable = 1'b1;
        bus.write_data   = 8'h33;
        bus.write_commit = 1'b1;
        tick();
        idle();
        chk("ws_lvl",   32'(bus.fill_level), 32'd1);
        chk("ws_empty", 32'(bus.fifo_empty), 32'd0);
        pop(1'b1);
        chk("ws_rd",     32'(bus.read_data),  32'h33);
        chk("ws_rd_lvl", 32'(bus.fill_level), 32'd0);

        // Packets straddling index 511 -> 0
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 300; i++) push(8'(i + 50 * k), i == 299);
            chk("wrap_lvl",   32'(bus.fill_level),  32'd300);
            chk("wrap_afull", 32'(bus.almost_full), 32'd0);
            for (int i = 0; i < 300; i++) begin
                pop(i == 299);
                chk("wrap_rd", 32'(bus.read_data), 32'((i + 50 * k) & 255));
            end
            chk("wrap_rel_lvl",   32'(bus.fill_level), 32'd0);
            chk("wrap_rel_empty", 32'(bus.fifo_empty), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/usb2ether_pkt_fifo.md
# usb2ether_pkt_fifo

Parametrised packet FIFO with commit/rollback on both sides, buffering bytes between the USB endpoint engine (writer) and the Ethernet MAC transmit path (reader). The writer builds a packet speculatively and either commits it (visible to the reader) or discards it on error. The reader can rewind to the last released point and replay, and frees space only on explicit release. It adds fill-level and almost-full reporting for upstream flow control.

## Interface
- DATA_WIDTH, 8, word width
- ADDR_WIDTH, 9, log2 of depth (DEPTH = 2**ADDR_WIDTH)
- AFULL_THRESH, 448, fill level at or above which almost_full asserts; legal range 1..DEPTH
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- clear  in  1  synchronous flush, same effect as rst
- write_enable  in  1  push write_data at write pointer
- write_data  in  DATA_WIDTH  word to push
- write_start  in  1  begin packet; rewinds write pointer to commit point
- write_commit  in  1  make all words written so far visible to reader
- write_error  in  1  discard uncommitted words
- read_enable  in  1  pop one committed word
- read_start  in  1  begin packet read; rewinds read pointer to release point
- read_done  in  1  release all words read so far (frees space)
- read_error  in  1  rewind read pointer to release point (replay)
- read_data  out  DATA_WIDTH  registered read word
- fifo_empty  out  1  no committed unread word
- fifo_full  out  1  no free entry
- almost_full  out  1  fill_level >= AFULL_THRESH
- fill_level  out  ADDR_WIDTH+1  entries held (written, not released)

## Operation
- Four pointers, each ADDR_WIDTH+1 bits with a wrap bit: wr_ptr, wr_cmt, rd_ptr, rd_rel. Memory index = low ADDR_WIDTH bits. All pointer arithmetic is modulo 2**(ADDR_WIDTH+1).
- Accepted write: write_enable & !fifo_full. Accepted read: read_enable & !fifo_empty. Rejected operations have no effect, no error flag.
- fifo_empty = (rd_ptr == wr_cmt). fill_level = wr_ptr - rd_rel. fifo_full = (fill_level == DEPTH).
- Write side priority per cycle: write_error > write_start > plain.
  - write_error: wr_ptr <= wr_cmt, and any same-cycle write is dropped. The write_commit is ignored.
  - write_start: a same-cycle accepted write lands at wr_cmt and wr_ptr <= wr_cmt+1. Without a write, wr_ptr <= wr_cmt.
  - A plain accepted write lands at wr_ptr, and wr_ptr increments.
  - write_commit (no error): wr_cmt <= the new wr_ptr value, so a same-cycle write is included in the commit.
- Read side priority per cycle: read_error > read_start > plain.
  - read_error: rd_ptr <= rd_rel, and any same-cycle read and read_done are ignored.
  - read_start: a same-cycle accepted read fetches from rd_rel and rd_ptr <= rd_rel+1.
  - read_done: rd_rel <= the new rd_ptr value, so a same-cycle read is included in the release.
- Full is evaluated against rd_rel, not rd_ptr. Read-but-unreleased words still occupy space.
- Reset and clear: all pointers 0, read_data 0, fifo_empty 1, fifo_full 0, almost_full 0, fill_level 0. Clear wins over every other input in the same cycle. Reset mid-packet discards everything, including committed data.

## Timing
- Flags and fill_level derive only from registered pointers, with no input-to-output combinational path.
- Write to memory is visible to the reader only after commit. fifo_empty deasserts the cycle after the write_commit edge.
- Read latency is 1 cycle. read_data updates on the edge that accepts the read and holds at all other times, including rejected reads and read_error.
- Space freed by read_done appears in fill_level and fifo_full the cycle after the read_done edge.
- Wrap-around is continuous: a packet may straddle index DEPTH-1 → 0.

## Structure
- Package usb2ether_pkg holds USB2ETHER_FIFO_DW=8, USB2ETHER_FIFO_AW=9 and USB2ETHER_FIFO_AFULL=448. Module parameters default to these constants.
- One sub-module, usb2ether_pkt_fifo_ram: simple dual-port DEPTH×DATA_WIDTH memory with a synchronous write port and a registered read port. It has no reset on the array.
- The top level holds pointer registers, priority logic and flag generation.

## Test plan
- Reset, then write 0xFF, commit, read: fifo_empty=1 until the cycle after commit. The cycle after the read, read_data=0xFF, fifo_empty=1, fill_level=1 until read_done, then 0.
- Write 0..511 with a commit on the last word: fifo_full=1 and fill_level=512, almost_full from the 448th word. A 513th write is ignored. Reads return 0..255 in order (8-bit wrap twice).
- Write 256 words and commit, then write 255 more and assert write_error: fill_level returns to 256. Reads return the first 256 values, then fifo_empty=1.
- Read 100 words without read_done, then read_error: read_start re-reads from word 0. fifo_full does not drop before read_done. After read_done, fill_level decreases by the words released.
- Simultaneous events: write_enable+write_commit in the same cycle includes the word. write_enable+write_error drops it. read_enable+read_done releases the word read. clear asserted with write_enable leaves fifo_empty=1 and fill_level=0.
- Wrap: cycle three 300-word packets through a 512-entry FIFO, committing, reading and releasing each one. Data is intact across index 511→0, and fill_level returns to 0 after each release.
